// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light controller and its safety monitor.
// Light, phase, fault and monitor-state encodings live here so both sides agree.
package semaforo_pkg;

  localparam logic [1:0] L_RED_OG = 2'b00;
  localparam logic [1:0] L_RED_OY = 2'b01;
  localparam logic [1:0] L_YEL    = 2'b10;
  localparam logic [1:0] L_GRN    = 2'b11;

  typedef enum logic [1:0] {PH_0, PH_1, PH_2, PH_3} phase_t;

  typedef enum logic [2:0] {
    F_NONE     = 3'd0,
    F_CONFLICT = 3'd1,
    F_PED      = 3'd2,
    F_SEQ      = 3'd3,
    F_SHORT    = 3'd4,
    F_STUCK    = 3'd5
  } fault_t;

  typedef enum logic [1:0] {SYNC, TRACK, FAULT} mon_state_t;

  // Cars may be moving on an avenue whenever its light shows yellow or green.
  function automatic logic cars_moving(input logic [1:0] c);
    return c[1];
  endfunction

endpackage

// File: rtl/semaforo_phase_decode.sv
// Maps one set of light codes onto a phase number plus pair/pedestrian legality.
// Purely combinational; phase is only meaningful while pair_ok is high.
module semaforo_phase_decode
  import semaforo_pkg::*;
(
  input  logic [1:0] c1,
  input  logic [1:0] c2,
  input  logic       p1,
  input  logic       p2,
  output phase_t     phase,
  output logic       pair_ok,
  output logic       ped_ok
);

  always_comb begin
    phase   = PH_0;
    pair_ok = 1'b1;
    case ({c1, c2})
      {L_GRN,    L_RED_OG}: phase = PH_0;
      {L_YEL,    L_RED_OY}: phase = PH_1;
      {L_RED_OG, L_GRN}:    phase = PH_2;
      {L_RED_OY, L_YEL}:    phase = PH_3;
      default:              pair_ok = 1'b0;
    endcase
    ped_ok = !((p1 && cars_moving(c1)) || (p2 && cars_moving(c2)));
  end

endmodule

// File: rtl/semaforo_monitor.sv
// Safety monitor for the traffic-light outputs: legality, phase order and dwell limits.
// Inputs pass through one register stage; all checks act on that stage.
//
//   state | meaning
//   SYNC  | waiting for a legal pair to lock onto
//   TRACK | following the phase sequence, counting dwell
//   FAULT | sticky fault latched, fail_safe asserted until fault_clr
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter int MIN_GREEN  = 8,
  parameter int MIN_YELLOW = 3,
  parameter int MAX_PHASE  = 64,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       c1,
  input  logic [1:0]       c2,
  input  logic             p1,
  input  logic             p2,
  input  logic             fault_clr,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             fail_safe,
  output logic [CNT_W-1:0] cycle_cnt
);

  logic [1:0]       s_c1_q, s_c2_q;
  logic             s_p1_q, s_p2_q, s_vld_q;
  mon_state_t       state_q, state_d;
  phase_t           phase_q, phase_d, dec_phase;
  logic [CNT_W-1:0] dwell_q, dwell_d, cyc_q, cyc_d, dwell_inc, min_dwell;
  fault_t           code_q, code_d, det;
  logic [1:0]       next_ph;
  logic             pair_ok, ped_ok;

  semaforo_phase_decode u_dec (
    .c1      (s_c1_q),
    .c2      (s_c2_q),
    .p1      (s_p1_q),
    .p2      (s_p2_q),
    .phase   (dec_phase),
    .pair_ok (pair_ok),
    .ped_ok  (ped_ok)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    dwell_d   = dwell_q;
    cyc_d     = cyc_q;
    code_d    = code_q;
    det       = F_NONE;
    next_ph   = phase_q + 2'd1;
    dwell_inc = (dwell_q == CNT_W'(MAX_PHASE)) ? dwell_q : dwell_q + 1'b1;
    min_dwell = phase_q[0] ? CNT_W'(MIN_YELLOW) : CNT_W'(MIN_GREEN);

    case (state_q)
      SYNC: begin
        if (s_vld_q) begin
          if (!pair_ok)     det = F_CONFLICT;
          else if (!ped_ok) det = F_PED;
          else begin
            phase_d = dec_phase;
            dwell_d = CNT_W'(1);
            state_d = TRACK;
          end
        end
      end
      TRACK: begin
        if (!pair_ok)                det = F_CONFLICT;
        else if (!ped_ok)            det = F_PED;
        else if (dec_phase == phase_q) begin
          dwell_d = dwell_inc;
          if (dwell_inc == CNT_W'(MAX_PHASE)) det = F_STUCK;
        end else if (dec_phase == next_ph) begin
          if (dwell_q < min_dwell) det = F_SHORT;
          else begin
            phase_d = dec_phase;
            dwell_d = CNT_W'(1);
            if (phase_q == PH_3) cyc_d = cyc_q + 1'b1;
          end
        end else                     det = F_SEQ;
      end
      FAULT: begin
        // Clearing is unconditional; a still-illegal input re-faults from SYNC.
        if (fault_clr) begin
          state_d = SYNC;
          code_d  = F_NONE;
          dwell_d = '0;
        end
      end
      default: state_d = SYNC;
    endcase

    if (det != F_NONE) begin
      state_d = FAULT;
      code_d  = det;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_c1_q  <= 2'b00;
      s_c2_q  <= 2'b00;
      s_p1_q  <= 1'b0;
      s_p2_q  <= 1'b0;
      s_vld_q <= 1'b0;
      state_q <= SYNC;
      phase_q <= PH_0;
      dwell_q <= '0;
      cyc_q   <= '0;
      code_q  <= F_NONE;
    end else begin
      s_c1_q  <= c1;
      s_c2_q  <= c2;
      s_p1_q  <= p1;
      s_p2_q  <= p2;
      s_vld_q <= 1'b1;
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      cyc_q   <= cyc_d;
      code_q  <= code_d;
    end
  end

  assign phase      = phase_q;
  assign locked     = (state_q == TRACK);
  assign fault      = (state_q == FAULT);
  assign fail_safe  = fault;
  assign fault_code = code_q;
  assign cycle_cnt  = cyc_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Bench for semaforo_monitor: directed scenarios with literal checks, then random
// traffic, all compared every cycle against a behavioural model of the monitor rules.
module tb_semaforo_monitor;

  localparam int MG = 4;
  localparam int MY = 2;
  localparam int MX = 20;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    c1, c2;
  logic          p1, p2, fault_clr;
  logic [1:0]    phase;
  logic          locked, fault, fail_safe;
  logic [2:0]    fault_code;
  logic [CW-1:0] cycle_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  semaforo_monitor #(.MIN_GREEN(MG), .MIN_YELLOW(MY), .MAX_PHASE(MX), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .c1(c1), .c2(c2), .p1(p1), .p2(p2), .fault_clr(fault_clr),
    .phase(phase), .locked(locked), .fault(fault), .fault_code(fault_code),
    .fail_safe(fail_safe), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Legal light pairs per phase, indexed by phase number.
  logic [1:0] pc1 [4] = '{2'b11, 2'b10, 2'b00, 2'b01};
  logic [1:0] pc2 [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int pair_phase(input logic [1:0] a, input logic [1:0] b);
    for (int i = 0; i < 4; i++)
      if (a == pc1[i] && b == pc2[i]) return i;
    return -1;
  endfunction

  // Behavioural model: mode 0 = hunting, 1 = following, 2 = faulted.
  int         m_mode, m_phase, m_run, m_cycles, m_code;
  bit         m_vld;
  logic [1:0] m_c1, m_c2;
  logic       m_p1, m_p2;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_phase = 0; m_run = 0; m_cycles = 0; m_code = 0; m_vld = 0;
    end else begin
      if (m_mode == 2) begin
        if (fault_clr) begin m_mode = 0; m_code = 0; m_run = 0; end
      end else if (m_vld) begin
        int ph, f;
        ph = pair_phase(m_c1, m_c2);
        f  = 0;
        if (ph < 0) f = 1;
        else if ((m_p1 && m_c1 >= 2) || (m_p2 && m_c2 >= 2)) f = 2;
        else if (m_mode == 0) begin m_mode = 1; m_phase = ph; m_run = 1; end
        else if (ph == m_phase) begin
          if (m_run + 1 >= MX) f = 5; else m_run++;
        end else if (ph == (m_phase + 1) % 4) begin
          if (m_run < ((m_phase % 2 == 0) ? MG : MY)) f = 4;
          else begin
            if (m_phase == 3) m_cycles = (m_cycles + 1) % 256;
            m_phase = ph; m_run = 1;
          end
        end else f = 3;
        if (f != 0) begin m_mode = 2; m_code = f; end
      end
      m_c1 = c1; m_c2 = c2; m_p1 = p1; m_p2 = p2; m_vld = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (phase !== 2'(m_phase) || locked !== (m_mode == 1) || fault !== (m_mode == 2) ||
          fail_safe !== (m_mode == 2) || fault_code !== 3'(m_code) || cycle_cnt !== CW'(m_cycles)) begin
        errors++;
        $display("FAIL model t=%0t got ph=%0d lk=%0b f=%0b fs=%0b code=%0d cyc=%0d want ph=%0d lk=%0b f=%0b code=%0d cyc=%0d",
                 $time, phase, locked, fault, fail_safe, fault_code, cycle_cnt,
                 m_phase, m_mode == 1, m_mode == 2, m_code, m_cycles);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic pa, input logic pb, input logic clr);
    @(negedge clk);
    c1 = a; c2 = b; p1 = pa; p2 = pb; fault_clr = clr;
  endtask

  task automatic hold_ph(input int ph, input int n);
    repeat (n) step(pc1[ph], pc2[ph], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clr_to(input int ph);
    step(pc1[ph], pc2[ph], 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int cur;
    rst = 1'b1; c1 = pc1[0]; c2 = pc2[0]; p1 = 1'b0; p2 = 1'b0; fault_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    lit("reset_fault", int'(fault), 0);
    lit("reset_locked", int'(locked), 0);
    rst = 1'b0;

    // Legal cycle
    hold_ph(0, 5); hold_ph(1, 3); hold_ph(2, 5); hold_ph(3, 3); hold_ph(0, 3);
    lit("t1_phase", int'(phase), 0);
    lit("t1_cycle", int'(cycle_cnt), 1);
    lit("t1_fault", int'(fault), 0);
    lit("t1_locked", int'(locked), 1);

    // Conflict
    repeat (3) step(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    lit("t2_fault", int'(fault), 1);
    lit("t2_code", int'(fault_code), 1);
    lit("t2_failsafe", int'(fail_safe), 1);
    lit("t2_locked", int'(locked), 0);

    // Pedestrian on avenue 1 then avenue 2
    clr_to(0); hold_ph(0, 3);
    repeat (3) step(pc1[0], pc2[0], 1'b1, 1'b0, 1'b0);
    lit("t3_ped1", int'(fault_code), 2);
    clr_to(2); hold_ph(2, 3);
    repeat (3) step(pc1[2], pc2[2], 1'b0, 1'b1, 1'b0);
    lit("t3_ped2", int'(fault_code), 2);

    // Skip and short dwell
    clr_to(0); hold_ph(0, 5); hold_ph(2, 3);
    lit("t4_seq", int'(fault_code), 3);
    clr_to(0); hold_ph(0, 1); hold_ph(1, 3);
    lit("t4_short", int'(fault_code), 4);

    // Stuck, then conflict taking precedence
    clr_to(0); hold_ph(0, 25);
    lit("t5_stuck", int'(fault_code), 5);
    clr_to(0); hold_ph(0, 1);
    repeat (3) step(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    lit("t5_conflict", int'(fault_code), 1);

    // Clear, relock, run to three cycles, reset mid-P1
    clr_to(0);
    step(pc1[0], pc2[0], 1'b0, 1'b0, 1'b0);
    lit("t6_clr_fault", int'(fault), 0);
    lit("t6_clr_code", int'(fault_code), 0);
    step(pc1[0], pc2[0], 1'b0, 1'b0, 1'b0);
    lit("t6_relock", int'(locked), 1);
    hold_ph(0, 3);
    repeat (2) begin hold_ph(1, 3); hold_ph(2, 5); hold_ph(3, 3); hold_ph(0, 5); end
    hold_ph(1, 2);
    lit("t6_cycle3", int'(cycle_cnt), 3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    lit("t6_rst_cycle", int'(cycle_cnt), 0);
    lit("t6_rst_phase", int'(phase), 0);
    lit("t6_rst_locked", int'(locked), 0);
    lit("t6_rst_fault", int'(fault) + int'(fail_safe) + int'(fault_code), 0);
    rst = 1'b0;

    // Random traffic
    cur = 0;
    for (int seg = 0; seg < 1200; seg++) begin
      int r, n;
      r = $urandom_range(0, 99);
      if (r < 70) begin
        cur = (cur + 1) % 4;
        n = $urandom_range(1, 8);
        repeat (n) begin
          logic a, b;
          a = pc1[cur][1] ? ($urandom_range(0, 29) == 0) : 1'($urandom);
          b = pc2[cur][1] ? ($urandom_range(0, 29) == 0) : 1'($urandom);
          step(pc1[cur], pc2[cur], a, b, 1'b0);
        end
      end else if (r < 80) begin
        cur = $urandom_range(0, 3);
        hold_ph(cur, $urandom_range(1, 4));
      end else if (r < 87) begin
        repeat ($urandom_range(1, 3))
          step(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      end else if (r < 97) begin
        clr_to(cur);
      end else begin
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
